// File: rtl/sync_fifo_param.sv
// sync_fifo_param: parametrised single-clock FIFO with thresholds, occupancy count and sticky error flags.
//
// Ports:
//   CLK, RESET        clock and synchronous active-high reset (RESET overrides every other input)
//   DATA_IN, WRITE    write data and write request
//   READ              read request
//   ERR_CLEAR         clears ERR_OVERFLOW / ERR_UNDERFLOW (a coincident new error keeps the flag set)
//   DATA_OUT          read data; DATA_VALID marks a freshly popped word
//   FULL, EMPTY       COUNT == DEPTH / COUNT == 0
//   ALMOST_FULL       COUNT >= ALMOST_FULL_THR
//   ALMOST_EMPTY      COUNT <= ALMOST_EMPTY_THR
//   COUNT             current occupancy
//   ERR_OVERFLOW      sticky: a write was rejected
//   ERR_UNDERFLOW     sticky: a read was rejected
//
// Build option FIFO_FWFT_EN: first-word-fall-through. DATA_OUT always presents the
// head entry and DATA_VALID = !EMPTY. Without it, an accepted read returns the head
// word one cycle later with a single-cycle DATA_VALID pulse.
module sync_fifo_param #(
  parameter int DATA_WIDTH       = 8,
  parameter int DEPTH            = 8,
  parameter int ALMOST_FULL_THR  = 6,
  parameter int ALMOST_EMPTY_THR = 2
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [DATA_WIDTH-1:0]    DATA_IN,
  input  logic                     WRITE,
  input  logic                     READ,
  input  logic                     ERR_CLEAR,
  output logic [DATA_WIDTH-1:0]    DATA_OUT,
  output logic                     DATA_VALID,
  output logic                     FULL,
  output logic                     EMPTY,
  output logic                     ALMOST_FULL,
  output logic                     ALMOST_EMPTY,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     ERR_OVERFLOW,
  output logic                     ERR_UNDERFLOW
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nxt;
  logic [CW-1:0] count_rd, count_nxt;
  logic rd_acc, wr_acc;
  // A read frees a slot in the same cycle, so a full FIFO still accepts a write alongside it.
  always_comb begin
    rd_acc     = READ && !EMPTY;
    wr_acc     = WRITE && (!FULL || rd_acc);
    count_rd   = COUNT - CW'(rd_acc);
    count_nxt  = count_rd + CW'(wr_acc);
    rd_ptr_nxt = rd_ptr + AW'(rd_acc);
  end
  always_ff @(posedge CLK)
    if (!RESET && wr_acc) mem[wr_ptr] <= DATA_IN;
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      COUNT         <= '0;
      FULL          <= 1'b0;
      EMPTY         <= 1'b1;
      ALMOST_FULL   <= 1'b0;
      ALMOST_EMPTY  <= 1'b1;
      ERR_OVERFLOW  <= 1'b0;
      ERR_UNDERFLOW <= 1'b0;
    end else begin
      wr_ptr        <= wr_ptr + AW'(wr_acc);
      rd_ptr        <= rd_ptr_nxt;
      COUNT         <= count_nxt;
      FULL          <= count_nxt == CW'(DEPTH);
      EMPTY         <= count_nxt == '0;
      ALMOST_FULL   <= count_nxt >= CW'(ALMOST_FULL_THR);
      ALMOST_EMPTY  <= count_nxt <= CW'(ALMOST_EMPTY_THR);
      ERR_OVERFLOW  <= (ERR_OVERFLOW && !ERR_CLEAR) || (WRITE && !wr_acc);
      ERR_UNDERFLOW <= (ERR_UNDERFLOW && !ERR_CLEAR) || (READ && !rd_acc);
    end
  end
`ifdef FIFO_FWFT_EN
  // When nothing older than this cycle's write remains, the new head is the incoming
  // word itself, which the memory does not hold yet.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      DATA_VALID <= count_nxt != '0;
      if (count_nxt != '0) DATA_OUT <= (count_rd == '0) ? DATA_IN : mem[rd_ptr_nxt];
    end
  end
`else
  always_ff @(posedge CLK) begin
    if (RESET) begin
      DATA_OUT   <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      DATA_VALID <= rd_acc;
      if (rd_acc) DATA_OUT <= mem[rd_ptr];
    end
  end
`endif
endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: directed plus randomized check of sync_fifo_param against a queue model.
module tb_sync_fifo_param;
  localparam int DW = 8, DEPTH = 8, AF = 6, AE = 2;
  logic CLK = 1'b0, RESET = 1'b1, WRITE = 1'b0, READ = 1'b0, ERR_CLEAR = 1'b0;
  logic [DW-1:0] DATA_IN = '0, DATA_OUT;
  logic DATA_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, ERR_OVERFLOW, ERR_UNDERFLOW;
  logic [$clog2(DEPTH):0] COUNT;
  int n_chk = 0, n_fail = 0;
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_dout = '0;
  logic m_valid = 1'b0, m_ovf = 1'b0, m_unf = 1'b0;
  sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ALMOST_FULL_THR(AF), .ALMOST_EMPTY_THR(AE)) dut (
    .CLK(CLK), .RESET(RESET), .DATA_IN(DATA_IN), .WRITE(WRITE), .READ(READ), .ERR_CLEAR(ERR_CLEAR),
    .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .FULL(FULL), .EMPTY(EMPTY),
    .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY), .COUNT(COUNT),
    .ERR_OVERFLOW(ERR_OVERFLOW), .ERR_UNDERFLOW(ERR_UNDERFLOW));
  always #5 CLK = ~CLK;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input logic w, input logic r, input logic [DW-1:0] d, input logic c = 1'b0, input logic rst = 1'b0);
    bit rd_ok, wr_ok;
    WRITE = w; READ = r; DATA_IN = d; ERR_CLEAR = c; RESET = rst;
    @(posedge CLK);
    if (rst) begin
      q.delete(); m_dout = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      rd_ok = r && q.size() > 0;
      wr_ok = w && (q.size() < DEPTH || rd_ok);
      m_valid = rd_ok;
      if (rd_ok) m_dout = q.pop_front();
      if (wr_ok) q.push_back(d);
      m_ovf = (m_ovf && !c) || (w && !wr_ok);
      m_unf = (m_unf && !c) || (r && !rd_ok);
    end
    #1;
    check("COUNT", 32'(COUNT), 32'(q.size()));
    check("FULL", 32'(FULL), 32'(q.size() == DEPTH));
    check("EMPTY", 32'(EMPTY), 32'(q.size() == 0));
    check("ALMOST_FULL", 32'(ALMOST_FULL), 32'(q.size() >= AF));
    check("ALMOST_EMPTY", 32'(ALMOST_EMPTY), 32'(q.size() <= AE));
    check("DATA_VALID", 32'(DATA_VALID), 32'(m_valid));
    check("DATA_OUT", 32'(DATA_OUT), 32'(m_dout));
    check("ERR_OVERFLOW", 32'(ERR_OVERFLOW), 32'(m_ovf));
    check("ERR_UNDERFLOW", 32'(ERR_UNDERFLOW), 32'(m_unf));
  endtask
  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'(8'h10 + i));
    check("plan1_full", 32'(FULL), 32'd1);
    cyc(1, 0, 8'hAA);
    check("plan2_ovf", 32'(ERR_OVERFLOW), 32'd1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, 0);
      check("plan2_data", 32'(DATA_OUT), 32'(8'h10 + i));
    end
    cyc(0, 1, 0);
    check("plan3_unf", 32'(ERR_UNDERFLOW), 32'd1);
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 1);
    check("plan3_unf_hold", 32'(ERR_UNDERFLOW), 32'd1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(1, 0, 8'($urandom));
    cyc(1, 1, 8'h55);
    check("plan4_count", 32'(COUNT), 32'd8);
    for (int i = 0; i < 8; i++) cyc(0, 1, 0);
    cyc(1, 1, 8'h66);
    check("plan4_count1", 32'(COUNT), 32'd1);
    cyc(0, 1, 0, 1);
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 0, 8'($urandom));
    for (int i = 0; i < 5; i++) cyc(0, 1, 0);
    for (int i = 0; i < 6; i++) cyc(1, 0, 8'(8'h20 + i));
    for (int i = 0; i < 6; i++) cyc(0, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 8'($urandom));
    cyc(1, 1, 8'h77, 0, 1);
    check("plan6_count", 32'(COUNT), 32'd0);
    cyc(1, 0, 8'h99);
    cyc(0, 1, 0);
    check("plan6_data", 32'(DATA_OUT), 32'h99);
    for (int p = 0; p < 20; p++) begin
      int pw;
      pw = (p % 3 == 0) ? 80 : (p % 3 == 1) ? 20 : 50;
      for (int i = 0; i < 100; i++)
        cyc($urandom_range(0, 99) < pw, $urandom_range(0, 99) < 100 - pw, 8'($urandom),
            $urandom_range(0, 9) == 0, $urandom_range(0, 199) == 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO. Generalises the team's 8x8 memory buffer to arbitrary width and depth, with programmable almost-full/almost-empty thresholds, occupancy count and sticky, clearable error flags. Sits between producer and consumer stages of the datapath. Both sides share one clock domain.

Parameters:
DATA_WIDTH, 8, bits per entry.
DEPTH, 8, number of entries; power of 2, >= 4.
ALMOST_FULL_THR, 6, ALMOST_FULL asserted when COUNT >= this value; range 1..DEPTH.
ALMOST_EMPTY_THR, 2, ALMOST_EMPTY asserted when COUNT <= this value; range 0..DEPTH-1.

Ports:
CLK  in  1  clock.
RESET  in  1  synchronous, active-high reset.
DATA_IN  in  DATA_WIDTH  write data.
WRITE  in  1  write request.
READ  in  1  read request.
ERR_CLEAR  in  1  clears the sticky error flags.
DATA_OUT  out  DATA_WIDTH  read data.
DATA_VALID  out  1  DATA_OUT carries a freshly popped word.
FULL  out  1  COUNT == DEPTH.
EMPTY  out  1  COUNT == 0.
ALMOST_FULL  out  1  COUNT >= ALMOST_FULL_THR.
ALMOST_EMPTY  out  1  COUNT <= ALMOST_EMPTY_THR.
COUNT  out  $clog2(DEPTH)+1  current occupancy.
ERR_OVERFLOW  out  1  sticky: a write was rejected.
ERR_UNDERFLOW  out  1  sticky: a read was rejected.

Behaviour:
- Interface: reset RESET, synchronous, active-high; clock CLK. All outputs are registered.
- Reset values: DATA_OUT=0, DATA_VALID=0, COUNT=0, FULL=0, EMPTY=1, ALMOST_FULL=0, ALMOST_EMPTY=1, both errors 0, both pointers 0. Storage array is not reset.
- RESET overrides every other input in the same cycle, including mid-burst. Contents are discarded.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. COUNT tracks occupancy separately; no pointer-extension-bit tricks are needed.
- Write accept condition: WRITE && (!FULL || read_accept). A write to a full FIFO is accepted if a read is accepted in the same cycle.
- Read accept condition: READ && !EMPTY. A read on an empty FIFO is rejected even if a write arrives in the same cycle.
- Read latency: accepted READ in cycle N gives DATA_OUT = head word and DATA_VALID=1 in cycle N+1. DATA_VALID is 1 for one cycle per accepted read. DATA_OUT holds its value when no read is accepted.
- COUNT update: next = COUNT + write_accept - read_accept. FULL, EMPTY, ALMOST_FULL and ALMOST_EMPTY are computed from the next COUNT, so they change in the same cycle as COUNT.
- Rejected WRITE sets ERR_OVERFLOW. Rejected READ sets ERR_UNDERFLOW. Neither changes pointers, COUNT or memory.
- Error flags stay set until ERR_CLEAR. If ERR_CLEAR coincides with a new error event, the flag stays 1.

Optional Feature:
Macro FIFO_FWFT_EN: first-word-fall-through mode.
- With the macro defined:
  - DATA_OUT always presents the head entry.
  - DATA_VALID = !EMPTY (registered).
  - An accepted READ pops the entry, and the next entry appears on the following cycle.
  - A word written into an empty FIFO appears on DATA_OUT with DATA_VALID=1 one cycle after the write.
  - Accept rules and error rules are unchanged.
- Without the macro: standard one-cycle read latency, as described above.

Test Plan:
1. Reset then 8 writes (0x10..0x17), DEPTH=8 -> COUNT steps 1..8; ALMOST_FULL=1 from COUNT=6; FULL=1 at 8; EMPTY=0 after the first write.
2. FIFO full, then WRITE=1 with 0xAA -> write rejected, ERR_OVERFLOW=1, COUNT stays 8. Then 8 reads -> DATA_OUT 0x10..0x17, each one cycle after its READ; EMPTY=1 at the end.
3. FIFO empty, READ=1 -> ERR_UNDERFLOW=1, DATA_VALID=0. ERR_CLEAR pulse -> both errors return to 0. ERR_CLEAR together with a rejected read -> ERR_UNDERFLOW stays 1.
4. Full FIFO with WRITE and READ together -> both accepted, COUNT stays 8, no overflow. Empty FIFO with both -> write accepted, read rejected, COUNT=1, ERR_UNDERFLOW=1.
5. Wrap-around: write 5, read 5, write 6 (0x20..0x25), read 6 -> data returned in order, no error flags, ALMOST_EMPTY=1 whenever COUNT<=2.
6. RESET asserted mid-burst with COUNT=4 -> next cycle all outputs at reset values; subsequent write/read returns only the new data.
